// File: rtl/uart_rx_frame.sv
// UART receiver: oversampled start/data/parity/stop recovery with configurable framing,
// presenting each frame through a valid/ack holding register with overrun detection.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 2,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_50M,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 uart_rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = 4;
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    // START compares the pre-increment count, so the sample lands OVERSAMPLE/2-1 ticks after detect
    localparam logic [CW-1:0] CNT_START = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [BW-1:0] BIT_DLAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_SLAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 sync1_q, sync2_q;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 ovr_q, ovr_d;
    logic                 done;
    logic                 done_ferr;
    logic                 rxd_s;
    logic                 mid;

    assign rxd_s = sync2_q;
    assign mid   = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sync1_q    <= uart_rxd;
            sync2_q    <= sync1_q;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    // Assembly shift register only feeds rx_data on completion, so it needs no reset
    always_ff @(posedge clk_50M) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        done      = 1'b0;
        done_ferr = ferr_q;

        case (state_q)
            S_IDLE: begin
                if (tick && !rxd_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (cnt_q == CNT_START) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (mid) begin
                        cnt_d = '0;
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bit_q == BW'(i)) shreg_d[i] = rxd_s;
                        end
                        if (bit_q == BIT_DLAST) begin
                            bit_d   = '0;
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    if (mid) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        perr_d  = ((^shreg_q) ^ rxd_s) != (PARITY == 2);
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (mid) begin
                        cnt_d  = '0;
                        ferr_d = ferr_q | ~rxd_s;
                        if (bit_q == BIT_SLAST) begin
                            done      = 1'b1;
                            done_ferr = ferr_q | ~rxd_s;
                            bit_d     = '0;
                            state_d   = done_ferr ? S_BREAK : S_IDLE;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (tick && rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register: a completion coincident with rx_ack replaces the held frame
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = ovr_q;
        if (done) begin
            if (!valid_q || rx_ack) begin
                data_d     = shreg_q;
                perr_out_d = perr_q;
                ferr_out_d = done_ferr;
                valid_d    = 1'b1;
                ovr_d      = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack && valid_q) begin
            valid_d    = 1'b0;
            perr_out_d = 1'b0;
            ferr_out_d = 1'b0;
            ovr_d      = 1'b0;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_out_q;
    assign frame_err   = ferr_out_q;
    assign overrun_err = ovr_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: default 8O1 instance plus a 7N2 instance with tick held high.
module tb_uart_rx_frame;

    logic       clk_50M = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overrun_err, busy;

    logic       tick7;
    logic       rxd7;
    logic       ack7;
    logic [6:0] rx_data7;
    logic       valid7, perr7, ferr7, ovr7, busy7;

    int checks = 0;
    int errors = 0;
    int tick_per = 50;
    int tcnt = 0;

    always #5 clk_50M = ~clk_50M;

    uart_rx_frame dut (
        .clk_50M(clk_50M), .reset_n(reset_n), .tick(tick), .uart_rxd(rxd), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx_frame #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16)) dut7 (
        .clk_50M(clk_50M), .reset_n(reset_n), .tick(tick7), .uart_rxd(rxd7), .rx_ack(ack7),
        .rx_data(rx_data7), .rx_valid(valid7), .parity_err(perr7), .frame_err(ferr7),
        .overrun_err(ovr7), .busy(busy7)
    );

    // tick for the next rising edge is settled 1 unit after the current one
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk_50M);
            #1;
            tick = (tcnt == 0);
            tcnt = (tcnt + 1 >= tick_per) ? 0 : tcnt + 1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50M);
            while (!tick) @(posedge clk_50M);
        end
    endtask

    function automatic logic odd_pbit(input logic [7:0] d);
        return ~(^d);
    endfunction

    // start, 8 data LSB first, parity, one stop; OVERSAMPLE ticks per bit
    task automatic send_main(input logic [7:0] d, input logic pbit, input logic stop);
        logic bits [11];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = pbit;
        bits[10] = stop;
        for (int j = 0; j < 11; j++) begin
            @(negedge clk_50M);
            rxd = bits[j];
            wait_ticks(16);
        end
    endtask

    task automatic send7(input logic [6:0] d, input logic s1, input logic s2);
        logic bits [10];
        bits[0] = 1'b0;
        for (int i = 0; i < 7; i++) bits[i+1] = d[i];
        bits[8] = s1;
        bits[9] = s2;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk_50M);
            rxd7 = bits[j];
            repeat (16) @(posedge clk_50M);
        end
    endtask

    task automatic ack_main();
        @(negedge clk_50M);
        rx_ack = 1'b1;
        @(posedge clk_50M);
        @(negedge clk_50M);
        rx_ack = 1'b0;
    endtask

    task automatic ack_dut7();
        @(negedge clk_50M);
        ack7 = 1'b1;
        @(posedge clk_50M);
        @(negedge clk_50M);
        ack7 = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       pbit, stop, exp_perr, exp_ferr;

        reset_n = 1'b0;
        rxd     = 1'b1;
        rxd7    = 1'b1;
        rx_ack  = 1'b0;
        ack7    = 1'b0;
        tick7   = 1'b1;
        repeat (3) @(posedge clk_50M);
        @(negedge clk_50M);
        reset_n = 1'b1;
        @(negedge clk_50M);
        chk("reset rx_data", rx_data, 0);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset errs", {parity_err, frame_err, overrun_err}, 0);
        chk("reset busy", busy, 0);
        chk("reset dut7 outs", {rx_data7, valid7, perr7, ferr7, ovr7, busy7}, 0);

        // Good 8O1 frame at one tick per 50 clocks
        wait_ticks(2);
        send_main(8'hA5, odd_pbit(8'hA5), 1'b1);
        @(negedge clk_50M);
        chk("A5 data", rx_data, 8'hA5);
        chk("A5 valid", rx_valid, 1);
        chk("A5 errs", {parity_err, frame_err, overrun_err}, 0);
        chk("A5 busy idle", busy, 0);
        ack_main();
        chk("A5 ack clears valid", rx_valid, 0);

        wait_ticks(1);
        send_main(8'hA5, 1'b0, 1'b1);
        @(negedge clk_50M);
        chk("A5 badpar data", rx_data, 8'hA5);
        chk("A5 badpar perr", parity_err, 1);
        chk("A5 badpar ferr", frame_err, 0);
        ack_main();
        chk("badpar ack clears", {rx_valid, parity_err}, 0);

        // Frame error followed by a held-low line
        tick_per = 3;
        wait_ticks(2);
        send_main(8'h3C, odd_pbit(8'h3C), 1'b0);
        wait_ticks(320);
        @(negedge clk_50M);
        chk("3C data", rx_data, 8'h3C);
        chk("3C valid", rx_valid, 1);
        chk("3C ferr", frame_err, 1);
        chk("3C perr", parity_err, 0);
        chk("3C no extra frames", overrun_err, 0);
        chk("3C busy in break", busy, 1);
        rxd = 1'b1;
        wait_ticks(3);
        @(negedge clk_50M);
        chk("break exit busy", busy, 0);
        ack_main();
        chk("3C ack clears", {rx_valid, frame_err}, 0);

        // Start glitch of 4 ticks
        wait_ticks(1);
        @(negedge clk_50M);
        rxd = 1'b0;
        wait_ticks(2);
        @(negedge clk_50M);
        chk("glitch busy rises", busy, 1);
        wait_ticks(2);
        @(negedge clk_50M);
        rxd = 1'b1;
        wait_ticks(3);
        @(negedge clk_50M);
        chk("glitch busy tick7", busy, 1);
        wait_ticks(1);
        @(negedge clk_50M);
        chk("glitch busy tick8", busy, 0);
        chk("glitch no valid", rx_valid, 0);

        // Back-to-back without ack: second frame dropped
        wait_ticks(1);
        send_main(8'h11, odd_pbit(8'h11), 1'b1);
        send_main(8'h22, odd_pbit(8'h22), 1'b1);
        @(negedge clk_50M);
        chk("b2b data kept", rx_data, 8'h11);
        chk("b2b overrun", overrun_err, 1);
        chk("b2b valid", rx_valid, 1);
        ack_main();
        chk("b2b ack clears", {rx_valid, parity_err, frame_err, overrun_err}, 0);

        // Back-to-back with ack on the second completion's edge
        wait_ticks(1);
        fork
            begin
                send_main(8'h11, odd_pbit(8'h11), 1'b1);
                send_main(8'h22, odd_pbit(8'h22), 1'b1);
            end
            begin
                @(negedge clk_50M);
                wait_ticks(343);
                @(negedge clk_50M);
                while (!tick) @(negedge clk_50M);
                rx_ack = 1'b1;
                @(posedge clk_50M);
                @(negedge clk_50M);
                rx_ack = 1'b0;
            end
        join
        @(negedge clk_50M);
        chk("b2b+ack data", rx_data, 8'h22);
        chk("b2b+ack overrun", overrun_err, 0);
        chk("b2b+ack valid", rx_valid, 1);
        ack_main();

        // Random frames against the framing rules
        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 3))
                0: tick_per = 1;
                1: tick_per = 2;
                2: tick_per = 3;
                default: tick_per = 5;
            endcase
            wait_ticks(4);
            d        = 8'($urandom);
            pbit     = odd_pbit(d) ^ ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 4) != 0);
            exp_perr = (((^d) ^ pbit) != 1'b1);
            exp_ferr = ~stop;
            send_main(d, pbit, stop);
            @(negedge clk_50M);
            rxd = 1'b1;
            chk("rand data", rx_data, d);
            chk("rand perr", parity_err, exp_perr);
            chk("rand ferr", frame_err, exp_ferr);
            chk("rand valid/ovr", {rx_valid, overrun_err}, 2'b10);
            ack_main();
            wait_ticks(4);
        end

        // 7N2 instance, tick every clock: latency of busy and rx_valid
        fork
            send7(7'h55, 1'b1, 1'b1);
            begin
                @(negedge clk_50M);
                repeat (2) @(posedge clk_50M);
                @(negedge clk_50M);
                chk("7n2 busy before detect", busy7, 0);
                @(posedge clk_50M);
                @(negedge clk_50M);
                chk("7n2 busy after detect", busy7, 1);
                repeat (150) @(posedge clk_50M);
                @(negedge clk_50M);
                chk("7n2 valid before", valid7, 0);
                @(posedge clk_50M);
                @(negedge clk_50M);
                chk("7n2 valid at edge", valid7, 1);
            end
        join
        @(negedge clk_50M);
        chk("7n2 data", rx_data7, 7'h55);
        chk("7n2 errs", {perr7, ferr7, ovr7}, 0);
        ack_dut7();
        chk("7n2 ack", valid7, 0);

        send7(7'h55, 1'b1, 1'b0);
        @(negedge clk_50M);
        rxd7 = 1'b1;
        chk("7n2 stop2 ferr", ferr7, 1);
        chk("7n2 stop2 data", rx_data7, 7'h55);
        chk("7n2 stop2 valid", valid7, 1);
        repeat (5) @(posedge clk_50M);
        @(negedge clk_50M);
        chk("7n2 break exit", busy7, 0);

        // Reset during data bit 3 of a third frame
        fork
            send7(7'h2A, 1'b1, 1'b1);
            begin
                @(negedge clk_50M);
                repeat (70) @(posedge clk_50M);
                @(negedge clk_50M);
                chk("7n2 busy mid frame", busy7, 1);
                reset_n = 1'b0;
                #1;
                chk("rst dut7 outs", {rx_data7, valid7, perr7, ferr7, ovr7, busy7}, 0);
                chk("rst main outs", {rx_data, rx_valid, parity_err, frame_err, overrun_err, busy}, 0);
            end
        join
        @(negedge clk_50M);
        reset_n = 1'b1;
        repeat (5) @(posedge clk_50M);
        @(negedge clk_50M);
        chk("post reset dut7 idle", {valid7, busy7}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
